// File: rtl/btn_debounce_if.sv
// btn_debounce_if: button-pin and debounced-event bundle between the board pins and control logic
// Ports (signals):
//   btn_n         raw active-low button pins (NUM_BTNS)
//   btn_level     debounced level, 1 = pressed (NUM_BTNS)
//   press_pulse   1-cycle strobe per accepted press / auto-repeat (NUM_BTNS)
//   release_pulse 1-cycle strobe per accepted release (NUM_BTNS)
//   any_pressed   OR of btn_level
// Modports: master = pin/consumer side, slave = debouncer.
interface btn_debounce_if #(
  parameter int NUM_BTNS = 4
);
  logic [NUM_BTNS-1:0] btn_n;
  logic [NUM_BTNS-1:0] btn_level;
  logic [NUM_BTNS-1:0] press_pulse;
  logic [NUM_BTNS-1:0] release_pulse;
  logic                any_pressed;
  modport master (output btn_n, input btn_level, press_pulse, release_pulse, any_pressed);
  modport slave (input btn_n, output btn_level, press_pulse, release_pulse, any_pressed);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: synchronise and debounce active-low push-buttons into clean levels and press/release strobes
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  btn_debounce_if.slave (btn_n in; btn_level, press_pulse, release_pulse, any_pressed out)
// Optional macro BTN_HOLD_REPEAT_EN: adds per-channel auto-repeat press pulses while a button is held.
module btn_debounce #(
  parameter int NUM_BTNS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input logic           clk,
  input logic           rst,
  btn_debounce_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  if (NUM_BTNS < 1 || NUM_BTNS > 8 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("btn_debounce: parameter out of range");
  end
  logic [NUM_BTNS-1:0] sync1, sync2, raw, lvl_n;
  logic                any;
  // Pins idle high, so the synchroniser resets to the released value.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      any   <= 1'b0;
    end else begin
      sync1 <= bus.btn_n;
      sync2 <= sync1;
      any   <= |lvl_n;
    end
  assign raw             = ~sync2;
  assign bus.any_pressed = any;
  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    state_t        st, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          lvl, pp, rp, rep;
    wire           term = cnt == CW'(DEBOUNCE_CYCLES - 1);
    always_comb begin
      st_n  = st;
      cnt_n = cnt;
      case (st)
        RELEASED:     if (raw[i]) begin st_n = PRESS_WAIT; cnt_n = '0; end
        PRESS_WAIT:   if (!raw[i]) begin st_n = RELEASED; cnt_n = '0; end
                      else if (term) st_n = PRESSED;
                      else cnt_n = cnt + 1'b1;
        PRESSED:      if (!raw[i]) begin st_n = RELEASE_WAIT; cnt_n = '0; end
        RELEASE_WAIT: if (raw[i]) st_n = PRESSED;
                      else if (term) st_n = RELEASED;
                      else cnt_n = cnt + 1'b1;
        default:      begin st_n = RELEASED; cnt_n = '0; end
      endcase
    end
    // Outputs are registered from the next state so they change together with it.
    assign lvl_n[i] = st_n == PRESSED || st_n == RELEASE_WAIT;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        st  <= RELEASED;
        cnt <= '0;
        lvl <= 1'b0;
        pp  <= 1'b0;
        rp  <= 1'b0;
      end else begin
        st  <= st_n;
        cnt <= cnt_n;
        lvl <= lvl_n[i];
        pp  <= (st == PRESS_WAIT && st_n == PRESSED) || rep;
        rp  <= st == RELEASE_WAIT && st_n == RELEASED;
      end
`ifdef BTN_HOLD_REPEAT_EN
    localparam int HW = $clog2(REPEAT_DELAY + 1);
    localparam int PW = REPEAT_PERIOD > 1 ? $clog2(REPEAT_PERIOD) : 1;
    logic [HW-1:0] hold, hold_n;
    logic [PW-1:0] per, per_n;
    wire           at_rd   = hold == HW'(REPEAT_DELAY);
    wire           per_end = per == PW'(REPEAT_PERIOD - 1);
    // hold saturates at REPEAT_DELAY; from then on per paces the repeat pulses.
    always_comb begin
      hold_n = st_n == RELEASED ? '0 : (st == PRESSED && !at_rd) ? hold + 1'b1 : hold;
      per_n  = st_n == RELEASED ? '0 : st != PRESSED ? per : !at_rd ? '0 : per_end ? '0 : per + 1'b1;
      rep    = st == PRESSED && (at_rd ? per_end : hold_n == HW'(REPEAT_DELAY));
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        hold <= '0;
        per  <= '0;
      end else begin
        hold <= hold_n;
        per  <= per_n;
      end
`else
    assign rep = 1'b0;
`endif
    assign bus.btn_level[i]     = lvl;
    assign bus.press_pulse[i]   = pp;
    assign bus.release_pulse[i] = rp;
  end
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed checks of btn_debounce with NUM_BTNS=2, DEBOUNCE_CYCLES=4
module tb_btn_debounce;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;
  int   npress;
  btn_debounce_if #(.NUM_BTNS(2)) bus ();
  btn_debounce #(
    .NUM_BTNS(2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [1:0] lvl, input logic [1:0] pp, input logic [1:0] rp);
    chk({tag, ".level"}, {6'd0, bus.btn_level}, {6'd0, lvl});
    chk({tag, ".press"}, {6'd0, bus.press_pulse}, {6'd0, pp});
    chk({tag, ".release"}, {6'd0, bus.release_pulse}, {6'd0, rp});
    chk({tag, ".any"}, {7'd0, bus.any_pressed}, {7'd0, |lvl});
  endtask
  initial begin
    bus.btn_n = 2'b00;
    tick(3);
    chk_all("in_reset", 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    tick(6);
    chk_all("rst_press_e5", 2'b00, 2'b00, 2'b00);
    tick(1);
    chk_all("rst_press_e6", 2'b11, 2'b11, 2'b00);
    tick(1);
    chk_all("rst_press_e7", 2'b11, 2'b00, 2'b00);
    bus.btn_n = 2'b11;
    tick(6);
    chk_all("rel_both_e5", 2'b11, 2'b00, 2'b00);
    tick(1);
    chk_all("rel_both_e6", 2'b00, 2'b00, 2'b11);
    tick(1);
    chk_all("rel_both_e7", 2'b00, 2'b00, 2'b00);
    bus.btn_n = 2'b10;
    tick(6);
    chk_all("press0_e5", 2'b00, 2'b00, 2'b00);
    tick(1);
    chk_all("press0_e6", 2'b01, 2'b01, 2'b00);
    tick(1);
    chk_all("press0_e7", 2'b01, 2'b00, 2'b00);
    bus.btn_n = 2'b11;
    tick(4);
    bus.btn_n = 2'b10;
    tick(2);
    bus.btn_n = 2'b11;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      chk_all("rel_glitch_hold", 2'b01, 2'b00, 2'b00);
    end
    tick(1);
    chk_all("rel_glitch_e6", 2'b00, 2'b00, 2'b01);
    tick(1);
    chk_all("rel_glitch_e7", 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 16; k++) begin
      bus.btn_n = (k < 3 || (k >= 4 && k < 7)) ? 2'b10 : 2'b11;
      tick(1);
      chk_all("bounce", 2'b00, 2'b00, 2'b00);
    end
    bus.btn_n = 2'b01;
    tick(7);
    chk_all("press1_e6", 2'b10, 2'b10, 2'b00);
    tick(2);
    rst = 1'b1;
    #1;
    chk_all("midrst_now", 2'b00, 2'b00, 2'b00);
    tick(2);
    chk_all("midrst_held", 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    tick(6);
    chk_all("repress1_e5", 2'b00, 2'b00, 2'b00);
    tick(1);
    chk_all("repress1_e6", 2'b10, 2'b10, 2'b00);
    bus.btn_n = 2'b11;
    tick(7);
    chk_all("rel1_e6", 2'b00, 2'b00, 2'b10);
    tick(2);
    bus.btn_n = 2'b10;
    tick(6);
    npress = 0;
    for (int k = 0; k < 25; k++) begin
      tick(1);
      npress += int'(bus.press_pulse[0]);
      chk({"hold_level"}, {6'd0, bus.btn_level}, 8'h01);
      chk({"hold_no_rel"}, {6'd0, bus.release_pulse}, 8'h00);
    end
`ifdef BTN_HOLD_REPEAT_EN
    chk("hold_pulses", 8'(npress), 8'd6);
`else
    chk("hold_pulses", 8'(npress), 8'd1);
`endif
    bus.btn_n = 2'b11;
    tick(12);
    chk_all("final_idle", 2'b00, 2'b00, 2'b00);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
